// File: rtl/lutram_fifo_pkg.sv
// lutram_fifo_pkg
// Shared sizing constants and the output-stage state type for the
// 64x8 distributed-RAM FIFO (lutram_fifo64x8) and its RAM (dpram64x8).
//   DEPTH : number of storage words
//   AW    : array address width
//   DW    : data width
//   CW    : occupancy counter width (holds 0..DEPTH)
// The output-stage state is only used when LUTRAM_FIFO_FWFT_EN is defined.
package lutram_fifo_pkg;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int CW    = 7;

    typedef enum logic {
        STG_EMPTY = 1'b0,
        STG_VALID = 1'b1
    } stg_state_t;

endpackage

// File: rtl/dpram64x8.sv
// dpram64x8
// 64x8 distributed dual-port RAM: one synchronous write port, one
// combinational read port. No reset; contents are whatever was last written.
// Ports:
//   CLK   in  write clock
//   WE    in  write enable
//   WADDR in  write address
//   DI    in  write data
//   RADDR in  read address
//   DO    out read data (combinational from RADDR)
module dpram64x8
    import lutram_fifo_pkg::*;
(
    input  logic          CLK,
    input  logic          WE,
    input  logic [AW-1:0] WADDR,
    input  logic [DW-1:0] DI,
    input  logic [AW-1:0] RADDR,
    output logic [DW-1:0] DO
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[WADDR] <= DI;
        end
    end

    assign DO = mem[RADDR];

endmodule

// File: rtl/lutram_fifo64x8.sv
// lutram_fifo64x8
// Synchronous 64-entry x 8-bit FIFO on a distributed RAM array.
// Handshake: a write is accepted when WR_EN && !FULL, a read when
// RD_EN && !EMPTY, both judged on the flag values present before the edge;
// a rejected request pulses OVERFLOW / UNDERFLOW for the following cycle.
// Optional macro LUTRAM_FIFO_FWFT_EN: first-word-fall-through mode, where a
// one-entry output stage presents the head word on DOUT whenever EMPTY = 0
// and RD_EN consumes it.
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   WR_EN, DIN     write request and data
//   FULL, ALMOST_FULL, OVERFLOW   write-side status
//   RD_EN, DOUT    read request and registered read data
//   EMPTY, ALMOST_EMPTY, UNDERFLOW read-side status
//   COUNT          occupancy 0..64 (includes the output stage in FWFT mode)
module lutram_fifo64x8
    import lutram_fifo_pkg::*;
#(
    parameter int ALMOST_FULL_THR  = 60,
    parameter int ALMOST_EMPTY_THR = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WR_EN,
    input  logic [DW-1:0] DIN,
    output logic          FULL,
    output logic          ALMOST_FULL,
    output logic          OVERFLOW,
    input  logic          RD_EN,
    output logic [DW-1:0] DOUT,
    output logic          EMPTY,
    output logic          ALMOST_EMPTY,
    output logic          UNDERFLOW,
    output logic [CW-1:0] COUNT
);

    localparam logic [CW-1:0] AF_THR   = CW'(ALMOST_FULL_THR);
    localparam logic [CW-1:0] AE_THR   = CW'(ALMOST_EMPTY_THR);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // One extra pointer bit so wr_ptr == rd_ptr unambiguously means the
    // array itself holds nothing (used by the FWFT refill logic).
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [DW-1:0] ram_do;
    logic          wr_acc;
    logic          rd_acc;
    logic          arr_pop;
    logic [CW-1:0] count_nxt;
    logic          empty_nxt;

    assign wr_acc = WR_EN && !FULL;

`ifdef LUTRAM_FIFO_FWFT_EN
    stg_state_t stg_state;
    stg_state_t stg_state_nxt;

    // The stage refills from the array whenever it is empty or its word is
    // being consumed this edge, provided the array has a word.
    assign rd_acc    = RD_EN && (stg_state == STG_VALID);
    assign arr_pop   = ((stg_state == STG_EMPTY) || rd_acc) && (wr_ptr != rd_ptr);
    assign stg_state_nxt = (arr_pop || (stg_state == STG_VALID && !rd_acc))
                         ? STG_VALID : STG_EMPTY;
    assign empty_nxt = (stg_state_nxt == STG_EMPTY);

    always_ff @(posedge CLK) begin
        if (RST) begin
            stg_state <= STG_EMPTY;
        end else begin
            stg_state <= stg_state_nxt;
        end
    end
`else
    assign rd_acc    = RD_EN && !EMPTY;
    assign arr_pop   = rd_acc;
    assign empty_nxt = (count_nxt == '0);
`endif

    assign count_nxt = COUNT + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_acc};

    dpram64x8 u_ram (
        .CLK   (CLK),
        .WE    (wr_acc),
        .WADDR (wr_ptr[AW-1:0]),
        .DI    (DIN),
        .RADDR (rd_ptr[AW-1:0]),
        .DO    (ram_do)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            COUNT        <= '0;
            DOUT         <= '0;
            EMPTY        <= 1'b1;
            FULL         <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
            ALMOST_FULL  <= 1'b0;
            OVERFLOW     <= 1'b0;
            UNDERFLOW    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (arr_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                DOUT   <= ram_do;
            end
            COUNT        <= count_nxt;
            EMPTY        <= empty_nxt;
            FULL         <= (count_nxt == FULL_CNT);
            ALMOST_EMPTY <= (count_nxt <= AE_THR);
            ALMOST_FULL  <= (count_nxt >= AF_THR);
            OVERFLOW     <= WR_EN && FULL;
            UNDERFLOW    <= RD_EN && !rd_acc;
        end
    end

endmodule

// File: tb/tb_lutram_fifo64x8.sv
// tb_lutram_fifo64x8
// Self-checking bench for lutram_fifo64x8 in its default (standard) mode.
// A behavioural model tracks occupancy and flags; written bytes are queued
// in exp_q and popped against DOUT when a read is accepted.
module tb_lutram_fifo64x8;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] din;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       rd_en;
    logic [7:0] dout;
    logic       empty;
    logic       almost_empty;
    logic       underflow;
    logic [6:0] count;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    int         m_cnt;
    logic [7:0] m_dout;
    logic [7:0] wdata;

    lutram_fifo64x8 #(
        .ALMOST_FULL_THR  (60),
        .ALMOST_EMPTY_THR (4)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .WR_EN        (wr_en),
        .DIN          (din),
        .FULL         (full),
        .ALMOST_FULL  (almost_full),
        .OVERFLOW     (overflow),
        .RD_EN        (rd_en),
        .DOUT         (dout),
        .EMPTY        (empty),
        .ALMOST_EMPTY (almost_empty),
        .UNDERFLOW    (underflow),
        .COUNT        (count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_status(input logic exp_ovf, input logic exp_unf);
        check("count",        32'(count),        32'(m_cnt));
        check("empty",        32'(empty),        32'(m_cnt == 0));
        check("full",         32'(full),         32'(m_cnt == 64));
        check("almost_full",  32'(almost_full),  32'(m_cnt >= 60));
        check("almost_empty", 32'(almost_empty), 32'(m_cnt <= 4));
        check("overflow",     32'(overflow),     32'(exp_ovf));
        check("underflow",    32'(underflow),    32'(exp_unf));
        check("dout",         32'(dout),         32'(m_dout));
    endtask

    // One clock of stimulus; model and checks are applied #1 after the edge.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd);
        logic m_full;
        logic m_empty;
        logic wa;
        logic ra;
        m_full  = (m_cnt == 64);
        m_empty = (m_cnt == 0);
        wa = wr && !m_full;
        ra = rd && !m_empty;
        wr_en = wr;
        din   = d;
        rd_en = rd;
        @(posedge clk);
        #1;
        if (ra) begin
            m_dout = exp_q.pop_front();
        end
        if (wa) begin
            exp_q.push_back(d);
        end
        m_cnt = m_cnt + int'(wa) - int'(ra);
        check_status(wr && m_full, rd && m_empty);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset(input logic wr, input logic [7:0] d);
        rst   = 1'b1;
        wr_en = wr;
        din   = d;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        exp_q.delete();
        m_cnt  = 0;
        m_dout = 8'h00;
        check_status(1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
        m_cnt = 0; m_dout = 8'h00;
        @(posedge clk);
        #1;
        do_reset(1'b0, 8'h00);

        // single word round trip
        step(1'b1, 8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("a5_dout", 32'(dout), 32'h0000_00A5);
        check("a5_empty", 32'(empty), 32'd1);

        // fill 00..3F, then one rejected write
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 8'(i), 1'b0);
        end
        check("fill_count", 32'(count), 32'd64);
        check("fill_full", 32'(full), 32'd1);
        step(1'b1, 8'hFF, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0);

        // drain, then one rejected read
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 8'h00, 1'b1);
        end
        check("drain_last", 32'(dout), 32'h3F);
        step(1'b0, 8'h00, 1'b1);
        check("unf_pulse", 32'(underflow), 32'd1);
        step(1'b0, 8'h00, 1'b0);

        // wrap-around: 40 in, 40 out, then streaming at COUNT = 1
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 8'h00, 1'b1);
        end
        step(1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
        end
        check("stream_count", 32'(count), 32'd1);

        // full with simultaneous read and write of 8'h77
        for (int i = 0; i < 63; i++) begin
            wdata = 8'($urandom_range(0, 118));
            step(1'b1, wdata, 1'b0);
        end
        check("full_again", 32'(full), 32'd1);
        step(1'b1, 8'h77, 1'b1);
        check("both_full_ovf", 32'(overflow), 32'd1);
        check("both_full_count", 32'(count), 32'd63);
        for (int i = 0; i < 63; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("no_77", 32'(dout == 8'h77), 32'd0);
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
        end

        // reset mid-operation at COUNT = 30, alongside WR_EN
        while (m_cnt > 0) begin
            step(1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 8'(i + 100), 1'b0);
        end
        check("pre_rst_count", 32'(count), 32'd30);
        do_reset(1'b1, 8'hEE);
        step(1'b1, 8'hC3, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("post_rst_dout", 32'(dout), 32'h0000_00C3);
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
